// File: rtl/boot_ram_loader.sv
// Boot RAM loader: parses a framed program image from a byte stream, writes the
// payload into the boot RAM from address 0, verifies an 8-bit checksum and holds
// the CPU in reset while a load is in progress.
module boot_ram_loader #(
  parameter int unsigned ADDR_W      = 11,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_ok,
  output logic              load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [16:0]      DEPTH_C  = 17'(1 << ADDR_W);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              ok_d, err_d;
  logic              accept, timeout;
  logic [15:0]       len_full;
  logic [7:0]        len_lo_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  idx_q;
  logic [7:0]        sum_q;
  logic [TMR_W-1:0]  timer_q;

  assign accept   = in_valid & in_ready;
  assign timeout  = (timer_q == TMR_LAST) && !accept;
  assign len_full = {in_data, len_lo_q};

  // Next-state decode; a byte accepted on the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          state_d = S_LEN_HI;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          if ((len_full == 16'd0) || ({1'b0, len_full} > DEPTH_C)) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          if ((idx_q + CNT_W'(1)) == len_q) state_d = S_CSUM;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = S_RESP;
          if (in_data == sum_q) ok_d = 1'b1;
          else                  err_d = 1'b1;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register plus registered outputs and frame datapath.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      in_ready <= 1'b0;
      ram_ce   <= 1'b0;
      ram_wre  <= 1'b0;
      ram_ad   <= '0;
      ram_din  <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      sum_q    <= '0;
      timer_q  <= '0;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d != S_RESP);
      busy     <= (state_d != S_IDLE);
      load_ok  <= ok_d;
      load_err <= err_d;
      ram_ce   <= 1'b0;
      ram_wre  <= 1'b0;

      if (accept || (state_q == S_IDLE) || (state_q == S_RESP)) timer_q <= '0;
      else                                                      timer_q <= timer_q + TMR_W'(1);

      if (ok_d) cpu_hold <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            sum_q    <= '0;
            idx_q    <= '0;
            cpu_hold <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (accept) len_lo_q <= in_data;
        end
        S_LEN_HI: begin
          if (accept) len_q <= CNT_W'(len_full);
        end
        S_DATA: begin
          if (accept) begin
            ram_ce  <= 1'b1;
            ram_wre <= 1'b1;
            ram_ad  <= idx_q[ADDR_W-1:0];
            ram_din <= in_data;
            sum_q   <= sum_q + in_data;
            idx_q   <= idx_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_ram_loader.sv
// Randomized scoreboard bench for boot_ram_loader.
module tb_boot_ram_loader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned T      = 40;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk, resetn, in_valid, in_ready;
  logic [7:0]        in_data;
  logic              ram_ce, ram_wre, cpu_hold, busy, load_ok, load_err;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;

  boot_ram_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .cpu_hold(cpu_hold), .busy(busy),
    .load_ok(load_ok), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = RAM write, 1 = load_ok, 2 = load_err
  typedef struct packed {
    logic [1:0]        kind;
    logic [ADDR_W-1:0] ad;
    logic [7:0]        din;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  // Monitor: every DUT write/response is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (resetn) begin
      if (ram_ce || ram_wre) begin
        chk("ce_eq_wre", 32'(ram_ce), 32'(ram_wre));
        if (exp_q.size() == 0) fail_now("unexpected_write", {ram_ad, ram_din});
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("write_kind", 32'(e.kind), 32'd0);
          chk("write_ad", 32'(ram_ad), 32'(e.ad));
          chk("write_din", 32'(ram_din), 32'(e.din));
        end
      end
      if (load_ok || load_err) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp", {load_ok, load_err});
        else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("resp", 32'({load_ok, load_err}), (e.kind == 2'd1) ? 32'd2 : (e.kind == 2'd2) ? 32'd1 : 32'd3);
        end
      end
    end
  end

  function automatic logic [7:0] sum8(input logic [7:0] p[$]);
    logic [7:0] s = 8'd0;
    foreach (p[i]) s = s + p[i];
    return s;
  endfunction

  task automatic push_ev(input logic [1:0] k, input int ad, input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.ad   = ADDR_W'(ad);
    e.din  = d;
    exp_q.push_back(e);
  endtask

  // Reference: a frame of declared length len yields len writes then ok/err,
  // or just err when the length is out of range.
  task automatic expect_frame(input int len, input logic [7:0] p[$], input logic [7:0] csum);
    if (len == 0 || len > int'(DEPTH)) push_ev(2'd2, 0, 8'd0);
    else begin
      for (int i = 0; i < len; i++) push_ev(2'd0, i, p[i]);
      push_ev((csum == sum8(p)) ? 2'd1 : 2'd2, 0, 8'd0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) fail_now("in_ready_wait", 32'(guard));
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] p[$], input logic [7:0] csum, input int maxgap);
    send_byte(8'hA5, 0);
    send_byte(8'(len), $urandom_range(0, maxgap));
    send_byte(8'(len >> 8), $urandom_range(0, maxgap));
    foreach (p[i]) send_byte(p[i], $urandom_range(0, maxgap));
    send_byte(csum, $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  task automatic rand_payload(input int len, output logic [7:0] p[$]);
    p = {};
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
  endtask

  task automatic run_frame(input logic [7:0] p[$], input logic [7:0] csum, input int maxgap);
    expect_frame(p.size(), p, csum);
    send_frame(p.size(), p, csum, maxgap);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p[$];
    int         k;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({in_ready, ram_ce, ram_wre, ram_ad, ram_din, cpu_hold, busy, load_ok, load_err}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // 1: directed good frame, back-to-back
    p = '{8'h11, 8'h22, 8'h33, 8'h44};
    expect_frame(4, p, 8'hAA);
    send_byte(8'hA5, 0);
    chk("hold_set", 32'(cpu_hold), 32'd1);
    chk("busy_set", 32'(busy), 32'd1);
    send_byte(8'h04, 0); send_byte(8'h00, 0);
    foreach (p[i]) send_byte(p[i], 0);
    send_byte(8'hAA, 0);
    wait_idle();
    chk("hold_clr_ok", 32'(cpu_hold), 32'd0);

    // 2: bad checksum keeps hold, good resend releases
    run_frame(p, 8'hAB, 0);
    chk("hold_after_err", 32'(cpu_hold), 32'd1);
    run_frame(p, 8'hAA, 0);
    chk("hold_after_resend", 32'(cpu_hold), 32'd0);

    // 3: junk ignored, LEN=0 rejected
    send_byte(8'h00, 0);
    chk("junk00_busy", 32'(busy), 32'd0);
    send_byte(8'hFF, 0);
    chk("junkff_busy", 32'(busy), 32'd0);
    p = {};
    expect_frame(0, p, 8'd0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_idle();
    chk("hold_len0", 32'(cpu_hold), 32'd1);

    // 4: LEN=2049 rejected, LEN=2048 fills RAM
    expect_frame(DEPTH + 1, p, 8'd0);
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h08, 0);
    wait_idle();
    rand_payload(DEPTH, p);
    run_frame(p, sum8(p), 0);
    chk("hold_full", 32'(cpu_hold), 32'd0);

    // 5a: timeout exactly T cycles after last accepted byte
    push_ev(2'd0, 0, 8'h11);
    push_ev(2'd2, 0, 8'd0);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    k = 0;
    for (int i = 1; i <= int'(T) + 5; i++) begin
      @(negedge clk);
      if (load_err && k == 0) k = i;
    end
    chk("timeout_latency", 32'(k), 32'(T));
    // 5b: byte on the final cycle wins over the timeout
    push_ev(2'd0, 0, 8'h11);
    push_ev(2'd0, 1, 8'h22);
    push_ev(2'd1, 0, 8'd0);
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h11, 0);
    repeat (T - 1) @(negedge clk);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    wait_idle();

    // 6: reset mid-frame
    push_ev(2'd0, 0, 8'h11);
    push_ev(2'd0, 1, 8'h22);
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    #1 resetn = 1'b0;
    #1 chk("midreset_outs", 32'({in_ready, ram_ce, ram_wre, ram_ad, ram_din, cpu_hold, busy, load_ok, load_err}), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rand_payload(6, p);
    run_frame(p, sum8(p), 1);

    // random frames with gaps and random checksum corruption
    for (int n = 0; n < 12; n++) begin
      rand_payload($urandom_range(1, 20), p);
      run_frame(p, ($urandom_range(0, 1) == 0) ? sum8(p) : sum8(p) + 8'($urandom_range(1, 255)), 2);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
